// File: rtl/cordic_pkg.sv
// Shared types and helpers for the iterative shift-add 2^x unit.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned ONE_MAXW = 128;

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // 1.0 in a Q.yf format, cast down to the real width by the caller.
    function automatic logic [ONE_MAXW-1:0] one_q(input int unsigned yf);
        return ONE_MAXW'(1) << yf;
    endfunction

endpackage

// File: rtl/cordic_exp_shift.sv
// Signed barrel shift of the mantissa by the integer exponent part.
// CORDIC_EXP2_SAT_EN adds saturation to all-ones with an overflow flag.
module cordic_exp_shift
    import cordic_pkg::*;
#(
    parameter int unsigned YW = 64,
    parameter int unsigned YF = 32,
    parameter int unsigned SW = 16
) (
    input  logic [YW-1:0] i_acc,
    input  logic [SW-1:0] i_sh,
`ifdef CORDIC_EXP2_SAT_EN
    output logic          o_ovf_c,
`endif
    output logic [YW-1:0] o_y_c
);

    logic          w_neg;
    logic [SW:0]   w_mag;
    logic [YW-1:0] w_left;
    logic [YW-1:0] w_right;
    logic [YW-1:0] w_raw;

    // Magnitude of the signed shift; one extra bit so the most negative value fits.
    assign w_neg   = i_sh[SW-1];
    assign w_mag   = w_neg ? ((SW+1)'(0) - {1'b1, i_sh}) : {1'b0, i_sh};
    assign w_left  = i_acc << w_mag;
    assign w_right = i_acc >> w_mag;
    assign w_raw   = w_neg ? w_right : w_left;

`ifdef CORDIC_EXP2_SAT_EN
    logic [YW-1:0] w_back;
    logic          w_lost;
    logic          w_big;

    // Any set bit pushed off the top shows up as a mismatch when shifted back.
    assign w_back  = w_left >> w_mag;
    assign w_lost  = (w_back != i_acc);
    assign w_big   = (w_mag >= (SW+1)'(YW - YF));
    assign o_ovf_c = !w_neg && (w_big || w_lost);
    assign o_y_c   = o_ovf_c ? {YW{1'b1}} : w_raw;
`else
    assign o_y_c   = w_raw;
`endif

endmodule

// File: rtl/cordic_exp2_iter.sv
// Iterative base-2 exponential y = 2^x, one shift-add step per clock, valid/ready on both sides.
// Optional saturation and ovf port with CORDIC_EXP2_SAT_EN.
module cordic_exp2_iter
    import cordic_pkg::*;
#(
    parameter int unsigned XW   = 32,
    parameter int unsigned XF   = 16,
    parameter int unsigned YW   = 64,
    parameter int unsigned YF   = 32,
    parameter int unsigned ITER = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ITER*XF-1:0] lookup,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XW-1:0]      x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [YW-1:0]      y,
`ifdef CORDIC_EXP2_SAT_EN
    output logic               ovf,
`endif
    output logic               busy
);

    localparam int unsigned IW = XW - XF;
    localparam int unsigned CW = cnt_w(ITER);
    localparam logic [YW-1:0] ONE = YW'(one_q(YF));

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_k;
    logic [XF-1:0] r_z;
    logic [YW-1:0] r_acc;
    logic [IW-1:0] r_i;
    logic [YW-1:0] r_y;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          r_busy;

    logic [XF-1:0] w_tab_arr [ITER];
    logic [XF-1:0] w_tab;
    logic          w_take;
    logic [YW-1:0] w_acc_sh;
    logic [YW-1:0] w_y_sh;

    // Slice the flat table into per-step entries.
    for (genvar g = 0; g < ITER; g++) begin : g_tab
        assign w_tab_arr[g] = lookup[g*XF +: XF];
    end

    assign w_tab    = w_tab_arr[r_k];
    assign w_take   = (r_z >= w_tab);
    assign w_acc_sh = r_acc >> ({1'b0, r_k} + (CW+1)'(1));

`ifdef CORDIC_EXP2_SAT_EN
    logic w_ovf;
    logic r_ovf;

    cordic_exp_shift #(.YW(YW), .YF(YF), .SW(IW)) u_shift (
        .i_acc   (r_acc),
        .i_sh    (r_i),
        .o_ovf_c (w_ovf),
        .o_y_c   (w_y_sh)
    );

    assign ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_ovf <= w_ovf;
        end
    end
`else
    cordic_exp_shift #(.YW(YW), .YF(YF), .SW(IW)) u_shift (
        .i_acc (r_acc),
        .i_sh  (r_i),
        .o_y_c (w_y_sh)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_nxt = CALC;
            CALC:    if (r_k == CW'(ITER - 1)) w_state_nxt = SHIFT;
            SHIFT:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered images of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == CALC) || (w_state_nxt == SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k   <= '0;
            r_z   <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_y   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_i   <= x[XW-1:XF];
                        r_z   <= x[XF-1:0];
                        r_acc <= ONE;
                        r_k   <= '0;
                    end
                end
                CALC: begin
                    if (w_take) begin
                        r_z   <= r_z - w_tab;
                        r_acc <= r_acc + w_acc_sh;
                    end
                    r_k <= r_k + CW'(1);
                end
                SHIFT: begin
                    r_y <= w_y_sh;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cordic_exp2_iter.sv
// Directed, table-driven bench for cordic_exp2_iter at default parameters.
// Expectations follow CORDIC_EXP2_SAT_EN when it is defined.
module tb_cordic_exp2_iter;

    localparam int unsigned XW   = 32;
    localparam int unsigned XF   = 16;
    localparam int unsigned YW   = 64;
    localparam int unsigned YF   = 32;
    localparam int unsigned ITER = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [ITER*XF-1:0] lookup;
    logic               in_valid;
    logic               in_ready;
    logic [XW-1:0]      x;
    logic               out_valid;
    logic               out_ready;
    logic [YW-1:0]      y;
    logic               busy;
`ifdef CORDIC_EXP2_SAT_EN
    logic               ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_exp2_iter #(.XW(XW), .XF(XF), .YW(YW), .YF(YF), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .lookup    (lookup),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
`ifdef CORDIC_EXP2_SAT_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] xv;
        logic [63:0] ey;
        logic [63:0] tol;
        logic        eovf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic chk_tol(input string nm, input logic [63:0] act, input logic [63:0] exp_v,
                           input logic [63:0] tol);
        logic [63:0] diff;
        diff = (act > exp_v) ? (act - exp_v) : (exp_v - act);
        checks++;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %h expected %h +/- %h", nm, act, exp_v, tol);
        end
    endtask

    function automatic logic get_ovf();
`ifdef CORDIC_EXP2_SAT_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Present x, then wait (bounded) for out_valid; lat = edges after the accept edge.
    task automatic run_op(input logic [31:0] xv, output logic [63:0] yv, output logic ov,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_op", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        x        = xv;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("in_ready_low_when_busy", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_seen", 64'(out_valid), 64'd1);
        yv = y;
        ov = get_ovf();
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_dropped", 64'(out_valid), 64'd0);
        chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] yv;
        logic        ov;
        int          lat;
        logic [63:0] half;

        for (int k = 0; k < int'(ITER); k++) begin
            real r;
            r = $ln(1.0 + 1.0 / $pow(2.0, real'(k + 1))) / $ln(2.0) * 65536.0;
            lookup[k*XF +: XF] = 16'($rtoi(r + 0.5));
        end

        half = 64'h0000_0001_6A09_E667;
        vecs[0]  = '{32'h0000_0000, 64'h0000_0001_0000_0000, 64'd0, 1'b0};
        vecs[1]  = '{32'h0001_0000, 64'h0000_0002_0000_0000, 64'd0, 1'b0};
        vecs[2]  = '{32'hFFFF_0000, 64'h0000_0000_8000_0000, 64'd0, 1'b0};
        vecs[3]  = '{32'h0000_8000, half,                    half >> 15, 1'b0};
        vecs[4]  = '{32'hFFFF_8000, half >> 1,               half >> 16, 1'b0};
        vecs[5]  = '{32'h0001_8000, half << 1,               half >> 14, 1'b0};
        vecs[6]  = '{32'h0002_8000, half << 2,               half >> 13, 1'b0};
        vecs[7]  = '{32'h0000_0001, 64'h0000_0001_0000_B172, 64'h0000_0000_0002_0000, 1'b0};
        vecs[8]  = '{32'h001F_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b0};
        vecs[9]  = '{32'hFFE0_0000, 64'd1,                   64'd0, 1'b0};
        vecs[10] = '{32'hFFDF_0000, 64'd0,                   64'd0, 1'b0};
        vecs[11] = '{32'h8000_0000, 64'd0,                   64'd0, 1'b0};
`ifdef CORDIC_EXP2_SAT_EN
        vecs[12] = '{32'h0020_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[13] = '{32'h7FFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
`else
        vecs[12] = '{32'h0020_0000, 64'd0,                   64'd0, 1'b0};
        vecs[13] = '{32'h7FFF_0000, 64'd0,                   64'd0, 1'b0};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y", y, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ovf", 64'(get_ovf()), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].xv, yv, ov, lat);
            // out_valid appears after the (ITER+1)th edge past accept: the (ITER+2)th cycle counting the accept cycle.
            if (i == 0) chk("latency", 64'(lat), 64'(ITER + 1));
            if (vecs[i].tol == 64'd0) chk($sformatf("vec%0d_y x=%h", i, vecs[i].xv), yv, vecs[i].ey);
            else chk_tol($sformatf("vec%0d_y x=%h", i, vecs[i].xv), yv, vecs[i].ey, vecs[i].tol);
            chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].eovf));
            chk($sformatf("vec%0d_busy_done", i), 64'(busy), 64'd0);
            finish_op();
        end

        // Back-pressure: result and flags hold while in_valid is ignored.
        run_op(32'hFFDF_0000, yv, ov, lat);
        in_valid = 1'b1;
        x        = 32'h0001_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_y", y, 64'd0);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        finish_op();

        // Leave a non-zero result behind before the abort test.
        run_op(32'h001F_0000, yv, ov, lat);
        chk("pre_abort_y", yv, 64'h8000_0000_0000_0000);
        finish_op();

        // Reset while the counter sits at k=7 in CALC.
        in_valid = 1'b1;
        x        = 32'h0000_8000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_y", y, 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("abort_no_stale_result", 64'(seen), 64'd0);
        end
        run_op(32'h0001_0000, yv, ov, lat);
        chk("post_abort_y", yv, 64'h0000_0002_0000_0000);
        chk("post_abort_latency", 64'(lat), 64'(ITER + 1));
        finish_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
